pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_gen_ras.sv | 50 +++++
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator (pc_gen, pc_gen_ras).
// Next-PC mode encoding and the sequential step size.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JAL    = 3'd2,
    SEL_JALR   = 3'd3,
    SEL_TRAP   = 3'd4,
    SEL_RET    = 3'd5
  } pc_sel_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_gen_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry when full.
// A simultaneous pop and push replaces the top entry in place.
module pc_gen_ras #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic [AW:0]     count
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   w_top_idx;
  logic            w_pop_ok;

  assign w_top_idx = r_ptr - AW'(1);
  assign w_pop_ok  = pop && (r_count != '0);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_pop_ok && !push) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (AW+1)'(1);
    end else if (push && !w_pop_ok) begin
      r_ptr <= r_ptr + AW'(1);
      if (r_count != (AW+1)'(DEPTH))
        r_count <= r_count + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the count gates every read of meaningful data.
  always_ff @(posedge clk) begin
    if (push)
      r_mem[w_pop_ok ? w_top_idx : r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator with misaligned-redirect detection.
// Define PC_GEN_RAS_EN to build the return-address stack used by RET.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            stall,
  input  logic [2:0]      sel,
  input  logic            cond,
  input  logic            is_call,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcplus4,
  output logic            misalign,
  output logic            ras_empty
);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_update;
  logic            w_redirect;
  logic            w_bad_align;
  logic            w_unused;

  assign pc_out     = r_pc;
  assign pcplus4    = r_pc + XLEN'(PC_STEP);
  assign misalign   = r_misalign;
  assign ras_empty  = w_ras_empty;
  // A trap may break through a stall; nothing else can.
  assign w_update   = pc_en && (!stall || (sel == SEL_TRAP));
  assign w_jalr_tgt = (rs1 + imm) & ~XLEN'(1);

  always_comb begin
    w_target   = pcplus4;
    w_redirect = 1'b0;
    case (sel)
      SEL_BRANCH: if (cond) begin
        w_target   = r_pc + imm;
        w_redirect = 1'b1;
      end
      SEL_JAL: begin
        w_target   = r_pc + imm;
        w_redirect = 1'b1;
      end
      SEL_JALR: begin
        w_target   = w_jalr_tgt;
        w_redirect = 1'b1;
      end
      SEL_TRAP: w_target = trap_vec & ~XLEN'(3);
      SEL_RET: begin
        w_target   = w_ras_empty ? w_jalr_tgt : w_ras_top;
        w_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_bad_align = w_redirect && (w_target[1:0] != 2'b00);

`ifdef PC_GEN_RAS_EN
  logic                       w_push;
  logic                       w_pop;
  logic [$clog2(RAS_DEPTH):0] w_ras_count;

  // A misaligned redirect is squashed entirely, including its stack effect.
  assign w_push = w_update && !w_bad_align && is_call &&
                  ((sel == SEL_JAL) || (sel == SEL_JALR));
  assign w_pop  = w_update && !w_bad_align && (sel == SEL_RET);

  pc_gen_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pcplus4),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .count     (w_ras_count)
  );

  assign w_unused = ^w_ras_count;
`else
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign w_unused    = is_call;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_update && w_bad_align;
      if (w_update && !w_bad_align)
        r_pc <= w_target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random stimulus
// against a queue-based reference model. Follows PC_GEN_RAS_EN like the RTL.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        stall;
  logic [2:0]  sel;
  logic        cond;
  logic        is_call;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] trap_vec;
  logic [31:0] pc_out;
  logic [31:0] pcplus4;
  logic        misalign;
  logic        ras_empty;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .stall     (stall),
    .sel       (sel),
    .cond      (cond),
    .is_call   (is_call),
    .imm       (imm),
    .rs1       (rs1),
    .trap_vec  (trap_vec),
    .pc_out    (pc_out),
    .pcplus4   (pcplus4),
    .misalign  (misalign),
    .ras_empty (ras_empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: next PC from the mode rules, RAS as a bounded queue.
  task automatic model_step();
    logic [31:0] tgt;
    logic        upd;
    logic        redir;
    upd   = pc_en && (!stall || sel == 3'd4);
    redir = 1'b0;
    tgt   = m_pc + 32'd4;
    case (sel)
      3'd1: if (cond) begin tgt = m_pc + imm; redir = 1'b1; end
      3'd2: begin tgt = m_pc + imm; redir = 1'b1; end
      3'd3: begin tgt = (rs1 + imm) & 32'hFFFF_FFFE; redir = 1'b1; end
      3'd4: tgt = trap_vec & 32'hFFFF_FFFC;
      3'd5: begin
        redir = 1'b1;
        if (RAS_ON && m_ras.size() > 0) tgt = m_ras[$];
        else tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
    m_mis = upd && redir && (tgt % 4 != 0);
    if (upd && !m_mis) begin
      if (RAS_ON) begin
        if (sel == 3'd5 && m_ras.size() > 0) void'(m_ras.pop_back());
        if ((sel == 3'd2 || sel == 3'd3) && is_call) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
      m_pc = tgt;
    end
    exp_q.push_back(m_pc);
  endtask

  task automatic check_model();
    check_eq("pc_out", pc_out, exp_q.pop_front());
    check_eq("pcplus4", pcplus4, m_pc + 32'd4);
    check_eq("misalign", {31'd0, misalign}, {31'd0, m_mis});
    check_eq("ras_empty", {31'd0, ras_empty}, RAS_ON ? {31'd0, m_ras.size() == 0} : 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic st, input logic [2:0] s, input logic c,
                       input logic call, input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] tv);
    pc_en = en; stall = st; sel = s; cond = c; is_call = call;
    imm = im; rs1 = r1; trap_vec = tv;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_pc(input logic [31:0] v);
    drive(1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 32'd0, 32'd0, v);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_mis = 1'b0;
    m_ras.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_mis", {31'd0, misalign}, 32'd0);
    check_eq("rst_ras_empty", {31'd0, ras_empty}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] held;

  initial begin
    rst = 1'b0; pc_en = 1'b0; stall = 1'b0; sel = 3'd0; cond = 1'b0;
    is_call = 1'b0; imm = '0; rs1 = '0; trap_vec = '0;
    model_reset();
    #2;
    check_eq("init_pc", pc_out, 32'h0);
    check_eq("init_ras_empty", {31'd0, ras_empty}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Sequential from reset
    drive(1, 0, 3'd0, 0, 0, 0, 0, 0); check_eq("seq1", pc_out, 32'h4);
    drive(1, 0, 3'd0, 0, 0, 0, 0, 0); check_eq("seq2", pc_out, 32'h8);
    drive(1, 0, 3'd0, 0, 0, 0, 0, 0); check_eq("seq3", pc_out, 32'hC);
    check_eq("seq_mis", {31'd0, misalign}, 32'd0);

    // Branch taken / not taken
    set_pc(32'h100);
    drive(1, 0, 3'd1, 1, 0, 32'hFFFF_FFF8, 0, 0); check_eq("br_taken", pc_out, 32'hF8);
    set_pc(32'h100);
    drive(1, 0, 3'd1, 0, 0, 32'hFFFF_FFF8, 0, 0); check_eq("br_nt", pc_out, 32'h104);

    // Call then return
    do_reset();
    set_pc(32'h200);
    drive(1, 0, 3'd2, 0, 1, 32'h40, 0, 0); check_eq("jal_call", pc_out, 32'h240);
    drive(1, 0, 3'd5, 0, 0, 32'h0, 32'h900, 0);
    check_eq("ret", pc_out, RAS_ON ? 32'h204 : 32'h900);
    check_eq("ret_empty", {31'd0, ras_empty}, 32'd1);

    // Misaligned JALR
    held = 32'h900;
    if (RAS_ON) held = 32'h204;
    drive(1, 0, 3'd3, 0, 1, 32'h2, 32'h1001, 0);
    check_eq("jalr_mis_pc", pc_out, held);
    check_eq("jalr_mis_pulse", {31'd0, misalign}, 32'd1);
    check_eq("jalr_mis_ras", {31'd0, ras_empty}, 32'd1);
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0);
    check_eq("jalr_mis_clear", {31'd0, misalign}, 32'd0);
    check_eq("jalr_mis_hold", pc_out, held);

    // Stall behaviour
    drive(1, 1, 3'd0, 0, 0, 0, 0, 0); check_eq("stall_seq", pc_out, held);
    drive(1, 1, 3'd4, 0, 0, 0, 0, 32'h8003); check_eq("stall_trap", pc_out, 32'h8000);

`ifdef PC_GEN_RAS_EN
    // Overflowing calls, then unwinding
    do_reset();
    set_pc(32'h0);
    for (int i = 0; i < 5; i++) drive(1, 0, 3'd2, 0, 1, 32'h10, 0, 0);
    check_eq("calls_pc", pc_out, 32'h50);
    drive(1, 0, 3'd5, 0, 0, 0, 32'h500, 0); check_eq("ret1", pc_out, 32'h44);
    drive(1, 0, 3'd5, 0, 0, 0, 32'h500, 0); check_eq("ret2", pc_out, 32'h34);
    drive(1, 0, 3'd5, 0, 0, 0, 32'h500, 0); check_eq("ret3", pc_out, 32'h24);
    check_eq("ret3_not_empty", {31'd0, ras_empty}, 32'd0);
    drive(1, 0, 3'd5, 0, 0, 0, 32'h500, 0); check_eq("ret4", pc_out, 32'h14);
    drive(1, 0, 3'd5, 0, 0, 0, 32'h500, 0); check_eq("ret5", pc_out, 32'h500);
    check_eq("ret5_empty", {31'd0, ras_empty}, 32'd1);
`else
    // RET ignores calls and follows the JALR target
    set_pc(32'h300);
    drive(1, 0, 3'd2, 0, 1, 32'h40, 0, 0); check_eq("nras_jal", pc_out, 32'h340);
    drive(1, 0, 3'd5, 0, 0, 32'h4, 32'h700, 0); check_eq("nras_ret", pc_out, 32'h704);
    check_eq("nras_empty", {31'd0, ras_empty}, 32'd1);
`endif

    // Async reset mid-stream, with a misalign pulse live and a SEQ pending
    set_pc(32'h300);
    drive(1, 0, 3'd3, 0, 0, 32'h2, 32'h1001, 0);
    check_eq("pre_rst_mis", {31'd0, misalign}, 32'd1);
    pc_en = 1'b1; stall = 1'b0; sel = 3'd0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_pc", pc_out, 32'h0);
    check_eq("async_mis", {31'd0, misalign}, 32'd0);
    check_eq("async_ras", {31'd0, ras_empty}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("in_rst_pc", pc_out, 32'h0);
    rst = 1'b1;
    model_reset();
    drive(1, 0, 3'd0, 0, 0, 0, 0, 0); check_eq("post_rst_seq", pc_out, 32'h4);

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r_imm, r_rs1, r_tv;
      logic [2:0]  r_sel;
      r_imm = $urandom_range(0, 511) - 32'd256;
      if ($urandom_range(0, 3) != 0) r_imm = r_imm & 32'hFFFF_FFFC;
      r_rs1 = $urandom;
      if ($urandom_range(0, 3) != 0) r_rs1 = r_rs1 & 32'hFFFF_FFFC;
      r_tv  = $urandom;
      r_sel = 3'($urandom_range(0, 7));
      if (r_sel == 3'd4 && $urandom_range(0, 1) == 0) r_sel = 3'd5;
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0), r_sel,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_imm, r_rs1, r_tv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
